// File: rtl/seg_pkg.sv
// Shared types and constants for the display page arbiter.
package seg_pkg;

    typedef enum logic [1:0] {
        HOME = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2
    } seg_arb_state_t;

    localparam logic [15:0] SEG_BLANK_WORD = 16'hFFFF;
    localparam int unsigned SEG_HOME_IDX   = 0;

endpackage

// File: rtl/seg_page_arb_if.sv
// Display-word bus between the readout sources, the arbiter and the segment driver.
interface seg_page_arb_if #(
    parameter int unsigned N_SRC = 3
) ();

    logic [N_SRC-1:0]    req;
    logic [16*N_SRC-1:0] val;
    logic [15:0]         disnum;
    logic [N_SRC-1:0]    grant;
    logic                busy;

    modport master (
        output req,
        output val,
        input  disnum,
        input  grant,
        input  busy
    );

    modport slave (
        input  req,
        input  val,
        output disnum,
        output grant,
        output busy
    );

endinterface

// File: rtl/seg_rr_pick.sv
// Round-robin pick of the first pending overlay strictly after last_i, cyclic over 1..N_SRC-1.
module seg_rr_pick #(
    parameter int unsigned N_SRC = 3,
    localparam int unsigned IdxW = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] pend_i,
    input  logic [IdxW-1:0]  last_i,
    output logic [IdxW-1:0]  tgt_o,
    output logic             any_o
);

    int unsigned     pos;
    logic [IdxW-1:0] idx;

    // Scan from the farthest candidate down so the nearest one after last_i wins.
    always_comb begin
        tgt_o = '0;
        any_o = 1'b0;
        pos   = 0;
        idx   = '0;
        for (int unsigned k = N_SRC - 1; k >= 1; k--) begin
            pos = ((32'(last_i) + k - 1) % (N_SRC - 1)) + 1;
            idx = IdxW'(pos);
            if (pend_i[idx]) begin
                tgt_o = idx;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_page_arb.sv
// Shares one 7-segment display word between a home page and round-robin timed overlays.
module seg_page_arb
    import seg_pkg::*;
#(
    parameter int unsigned N_SRC   = 3,
    parameter int unsigned DWELL   = 2000,
    parameter int unsigned GAP_CYC = 100
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    seg_page_arb_if.slave  bus
);

    localparam int unsigned IdxW = $clog2(N_SRC);
    localparam int unsigned DwW  = $clog2(DWELL);
    localparam int unsigned GapW = $clog2(GAP_CYC + 1);

    seg_arb_state_t   state_q, state_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [IdxW-1:0]  last_q, last_d;
    logic [IdxW-1:0]  tgt_q, tgt_d;
    logic [IdxW-1:0]  sel_q, sel_d;
    logic [DwW-1:0]   dw_q, dw_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic [15:0]      disnum_q, disnum_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic             busy_q, busy_d;

    logic [N_SRC-1:0] req_set;
    logic             restart;
    logic [IdxW-1:0]  pick_tgt;
    logic             pick_any;
    logic [15:0]      words [N_SRC];

    for (genvar g = 0; g < N_SRC; g++) begin : g_words
        assign words[g] = bus.val[16*g +: 16];
    end

    seg_rr_pick #(
        .N_SRC (N_SRC)
    ) u_pick (
        .pend_i (pend_q),
        .last_i (last_q),
        .tgt_o  (pick_tgt),
        .any_o  (pick_any)
    );

    // A request for the overlay already on screen extends it instead of queueing it again.
    always_comb begin
        req_set               = bus.req;
        req_set[SEG_HOME_IDX] = 1'b0;
        restart               = 1'b0;
        if (state_q == SHOW) begin
            req_set[sel_q] = 1'b0;
            restart        = bus.req[sel_q];
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | req_set;
        last_d  = last_q;
        tgt_d   = tgt_q;
        sel_d   = sel_q;
        dw_d    = dw_q;
        gap_d   = gap_q;
        unique case (state_q)
            HOME: begin
                if (pick_any) begin
                    state_d = GAP;
                    tgt_d   = pick_tgt;
                    gap_d   = '0;
                end
            end
            GAP: begin
                if (gap_q == GapW'(GAP_CYC - 1)) begin
                    gap_d = '0;
                    if (tgt_q != '0) begin
                        state_d        = SHOW;
                        sel_d          = tgt_q;
                        last_d         = tgt_q;
                        dw_d           = '0;
                        pend_d[tgt_q]  = 1'b0;
                    end else begin
                        state_d = HOME;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            SHOW: begin
                if (restart) begin
                    dw_d = '0;
                end else if (dw_q == DwW'(DWELL - 1)) begin
                    state_d = GAP;
                    gap_d   = '0;
                    tgt_d   = pick_any ? pick_tgt : '0;
                end else begin
                    dw_d = dw_q + 1'b1;
                end
            end
            default: begin
                state_d = HOME;
            end
        endcase
    end

    // Outputs follow the next state so they switch on the same edge as the FSM.
    always_comb begin
        disnum_d = SEG_BLANK_WORD;
        grant_d  = '0;
        busy_d   = 1'b1;
        unique case (state_d)
            HOME: begin
                disnum_d = words[SEG_HOME_IDX];
                grant_d  = N_SRC'(1) << SEG_HOME_IDX;
                busy_d   = 1'b0;
            end
            SHOW: begin
                disnum_d = words[sel_d];
                grant_d  = N_SRC'(1) << sel_d;
            end
            default: begin
                disnum_d = SEG_BLANK_WORD;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= HOME;
            pend_q   <= '0;
            last_q   <= IdxW'(N_SRC - 1);
            tgt_q    <= '0;
            sel_q    <= '0;
            dw_q     <= '0;
            gap_q    <= '0;
            disnum_q <= SEG_BLANK_WORD;
            grant_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            last_q   <= last_d;
            tgt_q    <= tgt_d;
            sel_q    <= sel_d;
            dw_q     <= dw_d;
            gap_q    <= gap_d;
            disnum_q <= disnum_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.disnum = disnum_q;
    assign bus.grant  = grant_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_seg_page_arb.sv
// Bench for seg_page_arb: directed scenarios plus random requests against a page-level model.
module tb_seg_page_arb;

    localparam int N     = 3;
    localparam int DWELL = 8;
    localparam int GAP   = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    seg_page_arb_if #(.N_SRC(N)) bus ();

    seg_page_arb #(
        .N_SRC   (N),
        .DWELL   (DWELL),
        .GAP_CYC (GAP)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: page -1 is the blank gap, 0 home, 1..N-1 an overlay; left counts cycles remaining.
    int          m_page;
    int          m_left;
    int          m_nxt;
    int          m_last;
    bit          m_pend [N];
    logic [15:0] exp_dis;
    logic [N-1:0] exp_grant;
    logic        exp_busy;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_of(input int i);
        return bus.val[16*i +: 16];
    endfunction

    // Walk forward from last, wrapping N-1 -> 1; 0 means nothing pending.
    function automatic int rr_next(input bit p [N], input int last);
        int idx;
        idx = last;
        for (int k = 0; k < N - 1; k++) begin
            idx = (idx == N - 1) ? 1 : idx + 1;
            if (p[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_page = 0;
        m_left = 0;
        m_nxt  = 0;
        m_last = N - 1;
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        exp_dis   = 16'hFFFF;
        exp_grant = '0;
        exp_busy  = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        int rr;
        rr = rr_next(m_pend, m_last);
        for (int i = 1; i < N; i++) begin
            if (r[i] && m_page != i) m_pend[i] = 1'b1;
        end
        if (m_page == 0) begin
            if (rr != 0) begin
                m_page = -1;
                m_left = GAP;
                m_nxt  = rr;
            end
        end else if (m_page == -1) begin
            m_left--;
            if (m_left == 0) begin
                if (m_nxt != 0) begin
                    m_page         = m_nxt;
                    m_last         = m_nxt;
                    m_left         = DWELL;
                    m_pend[m_nxt]  = 1'b0;
                end else begin
                    m_page = 0;
                end
            end
        end else begin
            if (r[m_page]) begin
                m_left = DWELL;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_page = -1;
                    m_left = GAP;
                    m_nxt  = rr;
                end
            end
        end
        if (m_page == 0) begin
            exp_dis   = word_of(0);
            exp_grant = N'(1);
            exp_busy  = 1'b0;
        end else if (m_page == -1) begin
            exp_dis   = 16'hFFFF;
            exp_grant = '0;
            exp_busy  = 1'b1;
        end else begin
            exp_dis   = word_of(m_page);
            exp_grant = N'(1) << m_page;
            exp_busy  = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".disnum"}, 32'(bus.disnum), 32'(exp_dis));
        check_val({tag, ".grant"}, 32'(bus.grant), 32'(exp_grant));
        check_val({tag, ".busy"}, 32'(bus.busy), 32'(exp_busy));
    endtask

    // Drive req for the coming edge, predict, then compare on the following falling edge.
    task automatic tick(input logic [N-1:0] r, input string tag);
        bus.req = r;
        model_step(r);
        @(negedge clk);
        bus.req = '0;
        check_outputs(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) tick('0, tag);
    endtask

    initial begin
        logic [N-1:0] r;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.val  = {16'h0A03, 16'h0012, 16'h1075};
        model_reset();

        repeat (3) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;
        tick('0, "release");
        idle(3, "home");

        // Single overlay: gap, dwell, gap, home.
        tick(3'b010, "req1");
        idle(16, "ovl1");

        // Simultaneous requests served in round-robin order.
        tick(3'b110, "req12");
        idle(34, "rr");

        // Re-request at dwell count 5 extends the overlay.
        tick(3'b010, "ext_req");
        idle(8, "ext_pre");
        tick(3'b010, "ext_restart");
        check_val("pend1_after_restart", 32'(dut.pend_q[1]), 32'(m_pend[1]));
        idle(14, "ext_post");

        // Live value tracking while shown.
        tick(3'b010, "live_req");
        idle(5, "live_pre");
        bus.val[31:16] = 16'h0013;
        idle(3, "live_track");
        bus.val[31:16] = 16'h0012;
        idle(10, "live_post");

        // Reset in the middle of an overlay with another request pending.
        tick(3'b010, "rst_req");
        idle(5, "rst_pre");
        tick(3'b100, "rst_pend2");
        tick('0, "rst_pre2");
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_async");
        repeat (2) @(negedge clk);
        check_outputs("rst_hold");
        rst_n = 1'b1;
        idle(30, "rst_after");

        // Random requests and value changes.
        for (int c = 0; c < 600; c++) begin
            r = '0;
            if ($urandom_range(0, 11) == 0) r[1] = 1'b1;
            if ($urandom_range(0, 11) == 0) r[2] = 1'b1;
            if ($urandom_range(0, 29) == 0) r[0] = 1'b1;
            if ($urandom_range(0, 19) == 0) begin
                bus.val[16*$urandom_range(0, N - 1) +: 16] = 16'($urandom);
            end
            tick(r, "rand");
        end
        idle(40, "drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
